// File: rtl/signed_divider.sv
// Sequential signed 32/16 restoring divider: magnitudes iterate MSB-first, signs are fixed up at the end.
// Define DIVIDER_SATURATE_EN to saturate quotient_out on overflow or divide by zero.
module signed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend_in,
  input  logic [15:0] divisor_in,
  output logic [15:0] quotient_out,
  output logic [15:0] remainder_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] lo_q, lo_d;
  logic        neg_dvd_q, neg_dvd_d, neg_quo_q, neg_quo_d, dz_q, dz_d;
  logic [15:0] qout_q, qout_d, rout_q, rout_d;
  logic        done_q, done_d, dzo_q, dzo_d, ovf_q, ovf_d;

  logic [16:0] rem_sh, rem_sub;
  logic [32:0] qs;
  logic        fits;
  logic [15:0] rem_fix;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[31]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    qs      = neg_quo_q ? (33'd0 - {1'b0, quo_q}) : {1'b0, quo_q};
    // 16-bit range holds iff bits 32..15 are a pure sign extension
    fits    = (qs[32:15] == '0) || (qs[32:15] == '1);
    rem_fix = neg_dvd_q ? (16'd0 - rem_q) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    lo_d      = lo_q;
    neg_dvd_d = neg_dvd_q;
    neg_quo_d = neg_quo_q;
    dz_d      = dz_q;
    qout_d    = qout_q;
    rout_d    = rout_q;
    dzo_d     = dzo_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_dvd_d = dividend_in[31];
          neg_quo_d = dividend_in[31] ^ divisor_in[15];
          dvd_d     = dividend_in[31] ? (32'd0 - dividend_in) : dividend_in;
          dvs_d     = divisor_in[15] ? (16'd0 - divisor_in) : divisor_in;
          lo_d      = dividend_in[15:0];
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          dz_d      = (divisor_in == 16'd0);
          state_d   = (divisor_in == 16'd0) ? FIX : CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[30:0], 1'b0};
        // remainder stays below |divisor| <= 32768, so the low 16 bits always suffice
        if (!rem_sub[16]) begin
          rem_d = rem_sub[15:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[15:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        dzo_d   = dz_q;
        if (dz_q) begin
          ovf_d  = 1'b0;
          rout_d = lo_q;
`ifdef DIVIDER_SATURATE_EN
          qout_d = neg_dvd_q ? 16'h8000 : 16'h7FFF;
`else
          qout_d = 16'hFFFF;
`endif
        end else begin
          ovf_d  = !fits;
          rout_d = rem_fix;
          qout_d = qs[15:0];
`ifdef DIVIDER_SATURATE_EN
          if (!fits) qout_d = qs[32] ? 16'h8000 : 16'h7FFF;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      lo_q      <= '0;
      neg_dvd_q <= 1'b0;
      neg_quo_q <= 1'b0;
      dz_q      <= 1'b0;
      qout_q    <= '0;
      rout_q    <= '0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      lo_q      <= lo_d;
      neg_dvd_q <= neg_dvd_d;
      neg_quo_q <= neg_quo_d;
      dz_q      <= dz_d;
      qout_q    <= qout_d;
      rout_q    <= rout_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign quotient_out  = qout_q;
  assign remainder_out = rout_q;
  assign div_by_zero   = dzo_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expectations come from signed / and % on 64-bit integers.
module tb_signed_divider;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] dividend_in;
  logic [15:0] divisor_in;
  logic [15:0] quotient_out, remainder_out;
  logic        busy, done, div_by_zero, overflow;

  signed_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .quotient_out(quotient_out), .remainder_out(remainder_out),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int cyc = 0, m_left = 0, n_cmp = 0, n_bad = 0, n_done = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int t0);
    exp_t   x;
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    x.t0 = t0; x.dz = 1'b0; x.ov = 1'b0;
    if (sb == 0) begin
      x.dz = 1'b1;
      x.r  = a[15:0];
`ifdef DIVIDER_SATURATE_EN
      x.q = (sa >= 0) ? 16'h7FFF : 16'h8000;
`else
      x.q = 16'hFFFF;
`endif
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      x.ov = (qq > 32767) || (qq < -32768);
      x.q  = qq[15:0];
      x.r  = rr[15:0];
`ifdef DIVIDER_SATURATE_EN
      if (x.ov) x.q = (qq > 0) ? 16'h7FFF : 16'h8000;
`endif
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Acceptance model: an idle divider takes start, then stays busy 33 cycles (1 for /0).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_left <= 0;
      exp_q.delete();
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
    end else if (start) begin
      exp_q.push_back(model(dividend_in, divisor_in, cyc));
      m_left <= (divisor_in == 16'd0) ? 1 : 33;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("quotient", 64'(quotient_out), 64'(e.q));
          check("remainder", 64'(remainder_out), 64'(e.r));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
          check("overflow", 64'(overflow), 64'(e.ov));
          check("latency", 64'(cyc - e.t0), e.dz ? 64'd2 : 64'd34);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_left != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (m_left != 0) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic op(input logic [31:0] a, input logic [15:0] b);
    wait_idle();
    start = 1'b1; dividend_in = a; divisor_in = b;
    @(negedge clk);
    start = 1'b0; dividend_in = $urandom; divisor_in = 16'($urandom);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_q"}, 64'(quotient_out), 64'd0);
    check({tag, "_r"}, 64'(remainder_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_dz"}, 64'(div_by_zero), 64'd0);
    check({tag, "_ov"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    logic signed [15:0] x, y;
    int p, d0;
    rst = 1'b1; start = 1'b0; dividend_in = '0; divisor_in = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    op(32'd7, -16'sd2);
    op(-32'sd7, 16'sd2);
    op(-32'sd7, -16'sd2);
    op(32'd0, 16'd5);
    op(32'h0001_0000, 16'd1);
    op(32'h8000_0000, 16'hFFFF);
    op(32'h8000_0000, 16'h8000);
    op(32'h7FFF_FFFF, 16'h8000);
    op(32'd1234, 16'd0);
    op(-32'sd5, 16'd0);

    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (y == 0) y = 16'sd1;
      p = int'(x) * int'(y);
      op(p, y);
    end
    for (int i = 0; i < 80; i++)
      op($urandom, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom));

    // start held high: exactly two operations
    wait_idle();
    @(negedge clk);
    d0 = n_done;
    start = 1'b1; dividend_in = 32'd100; divisor_in = 16'd7;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("held_start_ops", 64'(n_done - d0), 64'd2);

    // start pulse while busy is ignored
    wait_idle();
    @(negedge clk);
    d0 = n_done;
    op(32'd1000, 16'd10);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend_in = 32'd55; divisor_in = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ignored_start_ops", 64'(n_done - d0), 64'd1);

    // reset mid-operation discards it
    op(-32'sd99999, 16'sd321);
    wait_idle();
    @(negedge clk);
    d0 = n_done;
    op(32'd500000, 16'd77);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("reset_no_done", 64'(n_done - d0), 64'd0);
    op(-32'sd123456, 16'sd789);

    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
